// File: rtl/tbb_bus_writer.sv
// -----------------------------------------------------------------------------
// tbb_bus_writer
//
// Host-side initiator for the tbb1143 4-bit register-write bus (D[3:0], A0, WR).
// Byte commands arrive over a valid/ready handshake. Each command becomes one
// nibble write (low nibble) or two (low, then high), each built from a
// SETUP / STROBE / HOLD sequence with programmable cycle counts.
//
// Build option:
//   TBB_WR_FIFO_EN  defined   : FIFO_DEPTH-entry command FIFO in front of the
//                               FSM; commands can be accepted mid-transfer.
//                   undefined : single command register; cmd_ready is high
//                               only in IDLE or on the final HOLD cycle.
//
// Parameters:
//   SETUP_CYC   cycles D/A0 are stable before WR rises   (1..255)
//   PULSE_CYC   cycles WR is high                         (1..255)
//   HOLD_CYC    cycles D/A0 are held after WR falls       (1..255)
//   FIFO_DEPTH  command FIFO entries, power of 2, >= 2    (FIFO build only)
//
// Ports:
//   CLK        in   rising-edge clock
//   RST        in   synchronous reset, active-high
//   cmd_valid  in   command offered
//   cmd_ready  out  command accepted on an edge with cmd_valid & cmd_ready
//   cmd_data   in   [3:0] low nibble, [7:4] high nibble
//   cmd_a0     in   A0 level for every nibble of this command
//   cmd_wide   in   1: low then high nibble, 0: low nibble only
//   D          out  bus data
//   A0         out  bus address select
//   WR         out  write strobe, active-high
//   busy       out  FSM not idle, or a command is queued
//   wr_count   out  completed nibble writes, wraps 255 -> 0
// -----------------------------------------------------------------------------
module tbb_bus_writer #(
  parameter int unsigned SETUP_CYC  = 1,
  parameter int unsigned PULSE_CYC  = 2,
  parameter int unsigned HOLD_CYC   = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_data,
  input  logic       cmd_a0,
  input  logic       cmd_wide,
  output logic [3:0] D,
  output logic       A0,
  output logic       WR,
  output logic       busy,
  output logic [7:0] wr_count
);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // ---------------------------------------------------------------------------
  if (SETUP_CYC < 1 || SETUP_CYC > 255) begin : g_chk_setup
    $error("tbb_bus_writer: SETUP_CYC must be in 1..255");
  end
  if (PULSE_CYC < 1 || PULSE_CYC > 255) begin : g_chk_pulse
    $error("tbb_bus_writer: PULSE_CYC must be in 1..255");
  end
  if (HOLD_CYC < 1 || HOLD_CYC > 255) begin : g_chk_hold
    $error("tbb_bus_writer: HOLD_CYC must be in 1..255");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_chk_depth
    $error("tbb_bus_writer: FIFO_DEPTH must be a power of 2, at least 2");
  end

  // Per-state counters run 0 .. N-1; these are the terminal values.
  localparam logic [7:0] SETUP_LAST = 8'(SETUP_CYC - 1);
  localparam logic [7:0] PULSE_LAST = 8'(PULSE_CYC - 1);
  localparam logic [7:0] HOLD_LAST  = 8'(HOLD_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD
  } state_e;

  typedef struct packed {
    logic [7:0] data;
    logic       a0;
    logic       wide;
  } cmd_t;

  // ---------------------------------------------------------------------------
  // Signals
  // ---------------------------------------------------------------------------
  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  cmd_t       cur_q, cur_d;        // command being serialised
  logic       hi_q, hi_d;          // 1 while sending the high nibble
  logic [3:0] d_q, d_d;
  logic       a0_q, a0_d;
  logic       wr_q, wr_d;
  logic [7:0] wr_count_q, wr_count_d;
  logic       busy_q, busy_d;
  logic       cmd_ready_q, cmd_ready_d;

  cmd_t       in_cmd;
  logic       push;                // handshake completes on this edge
  logic       q_valid;             // a command is waiting in the queue
  cmd_t       q_head;
  logic       q_valid_d;           // queue occupancy after this edge
  logic       q_pop;               // FSM takes the queue head on this edge
  logic       bypass;              // FSM takes the incoming command directly
  logic       take;
  cmd_t       next_cmd;
  logic       final_hold_d;        // next cycle is the last HOLD cycle of the command

  assign in_cmd = {cmd_data, cmd_a0, cmd_wide};
  assign push   = cmd_valid & cmd_ready_q;

  // ---------------------------------------------------------------------------
  // Bus FSM: next state and registered-output values
  // ---------------------------------------------------------------------------
  // NOTE: every variable gets a default at the top of the block so that no
  // path through the case leaves it unassigned, which would infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 8'd1;
    cur_d      = cur_q;
    hi_d       = hi_q;
    d_d        = d_q;
    a0_d       = a0_q;
    wr_d       = wr_q;
    wr_count_d = wr_count_q;
    q_pop      = 1'b0;
    bypass     = 1'b0;
    take       = 1'b0;
    next_cmd   = q_head;

    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        // Starting from IDLE always goes through the queue, giving a fixed
        // one-cycle latency from acceptance to D/A0 valid.
        if (q_valid) begin
          q_pop = 1'b1;
          take  = 1'b1;
        end
      end

      ST_SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          state_d = ST_STROBE;
          cnt_d   = '0;
          wr_d    = 1'b1;
        end
      end

      ST_STROBE: begin
        if (cnt_q == PULSE_LAST) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
          wr_d    = 1'b0;
        end
      end

      ST_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          wr_count_d = wr_count_q + 8'd1;
          cnt_d      = '0;
          if (cur_q.wide && !hi_q) begin
            state_d = ST_SETUP;
            hi_d    = 1'b1;
            d_d     = cur_q.data[7:4];
          end else if (q_valid) begin
            q_pop = 1'b1;
            take  = 1'b1;
          end else if (push) begin
            // A command accepted on this very edge starts straight away,
            // so back-to-back traffic has no IDLE gap.
            bypass   = 1'b1;
            take     = 1'b1;
            next_cmd = in_cmd;
          end else begin
            state_d = ST_IDLE;
            d_d     = '0;
            a0_d    = 1'b0;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        wr_d    = 1'b0;
        d_d     = '0;
        a0_d    = 1'b0;
      end
    endcase

    if (take) begin
      state_d = ST_SETUP;
      cnt_d   = '0;
      cur_d   = next_cmd;
      hi_d    = 1'b0;
      d_d     = next_cmd.data[3:0];
      a0_d    = next_cmd.a0;
      wr_d    = 1'b0;
    end

    final_hold_d = (state_d == ST_HOLD) && (cnt_d == HOLD_LAST) &&
                   (!cur_d.wide || hi_d);
  end

  assign busy_d = (state_d != ST_IDLE) || q_valid_d;

  // ---------------------------------------------------------------------------
  // Command queue
  // ---------------------------------------------------------------------------
`ifdef TBB_WR_FIFO_EN
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] CNT_FULL = (PTR_W + 1)'(FIFO_DEPTH);

  cmd_t             mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             fifo_wr;

  assign fifo_wr = push & ~bypass;
  assign q_valid = (count_q != '0);
  assign q_head  = mem_q[rd_ptr_q];

  always_comb begin
    rd_ptr_d  = rd_ptr_q + PTR_W'(q_pop);
    wr_ptr_d  = wr_ptr_q + PTR_W'(fifo_wr);
    count_d   = count_q + (PTR_W + 1)'(fifo_wr) - (PTR_W + 1)'(q_pop);
    q_valid_d = (count_d != '0);
    // Ready is also raised when a pop is certain on the next edge, so a
    // full FIFO still accepts a push that coincides with a pop.
    cmd_ready_d = (count_d != CNT_FULL) || final_hold_d || (state_d == ST_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the FIFO storage is deliberately not reset; the pointers and count
  // define which entries are meaningful, so clearing the array buys nothing.
  always_ff @(posedge CLK) begin
    if (fifo_wr) begin
      mem_q[wr_ptr_q] <= in_cmd;
    end
  end
`else
  logic pend_valid_q, pend_valid_d;
  cmd_t pend_q, pend_d;

  assign q_valid = pend_valid_q;
  assign q_head  = pend_q;

  always_comb begin
    pend_valid_d = pend_valid_q;
    pend_d       = pend_q;
    if (q_pop) begin
      pend_valid_d = 1'b0;
    end
    if (push && !bypass) begin
      pend_valid_d = 1'b1;
      pend_d       = in_cmd;
    end
    q_valid_d   = pend_valid_d;
    cmd_ready_d = ((state_d == ST_IDLE) && !pend_valid_d) || final_hold_d;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pend_valid_q <= 1'b0;
    end else begin
      pend_valid_q <= pend_valid_d;
    end
  end

  always_ff @(posedge CLK) begin
    pend_q <= pend_d;
  end
`endif

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential blocks use non-blocking assignments so every flop samples
  // the pre-edge values; the combinational blocks above use blocking ones.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      hi_q        <= 1'b0;
      d_q         <= '0;
      a0_q        <= 1'b0;
      wr_q        <= 1'b0;
      wr_count_q  <= '0;
      busy_q      <= 1'b0;
      cmd_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hi_q        <= hi_d;
      d_q         <= d_d;
      a0_q        <= a0_d;
      wr_q        <= wr_d;
      wr_count_q  <= wr_count_d;
      busy_q      <= busy_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end

  // Command payload is only meaningful while the FSM is active.
  always_ff @(posedge CLK) begin
    cur_q <= cur_d;
  end

  assign D         = d_q;
  assign A0        = a0_q;
  assign WR        = wr_q;
  assign busy      = busy_q;
  assign wr_count  = wr_count_q;
  assign cmd_ready = cmd_ready_q;

endmodule
